// File: rtl/range_stream_gen.sv
// range_stream_gen: buffers samples, replays them as a go-framed stream, then captures the finder's range/error.
// Define RANGE_GEN_CHECK_EN to build the incremental min/max self-check that drives mismatch.
module range_stream_gen #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       load_valid,
  input  logic [WIDTH-1:0]           load_data,
  input  logic                       start,
  output logic [WIDTH-1:0]           data_out,
  output logic                       go_out,
  input  logic                       finish_in,
  input  logic [WIDTH-1:0]           range_in,
  input  logic                       error_in,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           result,
  output logic                       rx_error,
  output logic                       timeout,
  output logic                       mismatch,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [2**AW];
  logic [CW-1:0]    count_q, count_d, idx_q, idx_d;
  logic [TW-1:0]    wcnt_q, wcnt_d;
  logic [WIDTH-1:0] data_q, data_d, result_q, result_d;
  logic             go_q, go_d, rxerr_q, rxerr_d, timeout_q, timeout_d;
  logic             mismatch_q, mismatch_d, overflow_q, overflow_d;
  logic             idle_done, do_clear, do_load, do_start, full, chk;

  assign idle_done = state_q == IDLE || state_q == DONE;
  assign do_clear  = clear && idle_done;
  assign full      = count_q == CW'(DEPTH);
  assign do_load   = load_valid && idle_done && !do_clear && !full;
  assign do_start  = start && idle_done && !do_clear;

`ifdef RANGE_GEN_CHECK_EN
  logic [WIDTH-1:0] min_q, max_q;
  always_ff @(posedge clock) begin
    if (reset || do_clear) begin
      min_q <= '0;
      max_q <= '0;
    end else if (do_load) begin
      min_q <= (count_q == '0 || load_data < min_q) ? load_data : min_q;
      max_q <= (count_q == '0 || load_data > max_q) ? load_data : max_q;
    end
  end
  assign chk = range_in != max_q - min_q && !error_in;
`else
  assign chk = 1'b0;
`endif

  always_ff @(posedge clock)
    if (do_load) mem_q[count_q[AW-1:0]] <= load_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      idx_q      <= '0;
      wcnt_q     <= '0;
      data_q     <= '0;
      go_q       <= 1'b0;
      result_q   <= '0;
      rxerr_q    <= 1'b0;
      timeout_q  <= 1'b0;
      mismatch_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      wcnt_q     <= wcnt_d;
      data_q     <= data_d;
      go_q       <= go_d;
      result_q   <= result_d;
      rxerr_q    <= rxerr_d;
      timeout_q  <= timeout_d;
      mismatch_q <= mismatch_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q + CW'(do_load);
    idx_d      = idx_q;
    wcnt_d     = wcnt_q;
    data_d     = data_q;
    go_d       = go_q;
    result_d   = result_q;
    rxerr_d    = rxerr_q;
    timeout_d  = timeout_q;
    mismatch_d = mismatch_q;
    overflow_d = overflow_q || (load_valid && idle_done && !do_clear && full);
    if (do_clear) begin
      state_d    = IDLE;
      count_d    = '0;
      data_d     = '0;
      go_d       = 1'b0;
      result_d   = '0;
      rxerr_d    = 1'b0;
      timeout_d  = 1'b0;
      mismatch_d = 1'b0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        SEND: begin
          // idx_q is the next sample to emit; once it reaches count the frame is over
          if (idx_q == count_q) begin
            state_d = WAIT;
            go_d    = 1'b0;
            data_d  = '0;
            wcnt_d  = '0;
          end else begin
            go_d   = 1'b1;
            data_d = mem_q[idx_q[AW-1:0]];
            idx_d  = idx_q + CW'(1);
          end
        end
        WAIT: begin
          if (finish_in) begin
            state_d    = DONE;
            result_d   = range_in;
            rxerr_d    = error_in;
            mismatch_d = chk;
          end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
            state_d   = DONE;
            timeout_d = 1'b1;
            result_d  = '0;
          end else begin
            wcnt_d = wcnt_q + TW'(1);
          end
        end
        default: begin
          if (do_start) begin
            state_d    = count_d != '0 ? SEND : DONE;
            idx_d      = '0;
            result_d   = '0;
            rxerr_d    = 1'b0;
            timeout_d  = 1'b0;
            mismatch_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    busy     = state_q == SEND || state_q == WAIT;
    done     = state_q == DONE;
    data_out = data_q;
    go_out   = go_q;
    result   = result_q;
    rx_error = rxerr_q;
    timeout  = timeout_q;
    mismatch = mismatch_q;
    count    = count_q;
    overflow = overflow_q;
  end
endmodule

// File: tb/tb_range_stream_gen.sv
// tb_range_stream_gen: randomized scenario bench for range_stream_gen against a queue-based model.
module tb_range_stream_gen;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 20;
  localparam int CW      = $clog2(DEPTH + 1);
`ifdef RANGE_GEN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clock = 1'b0, reset, clear, load_valid, start, finish_in, error_in;
  logic [WIDTH-1:0] load_data, range_in, data_out, result;
  logic             go_out, busy, done, rx_error, timeout, mismatch, overflow;
  logic [CW-1:0]    count;

  int               checks = 0, errors = 0;
  logic [WIDTH-1:0] mq[$];

  range_stream_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .clear(clear), .load_valid(load_valid), .load_data(load_data),
    .start(start), .data_out(data_out), .go_out(go_out), .finish_in(finish_in), .range_in(range_in),
    .error_in(error_in), .busy(busy), .done(done), .result(result), .rx_error(rx_error),
    .timeout(timeout), .mismatch(mismatch), .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] v);
    load_valid = 1'b1;
    load_data  = v;
    tick();
    load_valid = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(v);
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    mq.delete();
  endtask

  function automatic logic [WIDTH-1:0] model_range;
    logic [WIDTH-1:0] lo, hi;
    if (mq.size() == 0) return '0;
    lo = mq[0];
    hi = mq[0];
    foreach (mq[i]) begin
      if (mq[i] < lo) lo = mq[i];
      if (mq[i] > hi) hi = mq[i];
    end
    return hi - lo;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (count !== 0 || go_out !== 0 || data_out !== 0 || busy !== 0 || done !== 0 || result !== 0 ||
        rx_error !== 0 || timeout !== 0 || mismatch !== 0 || overflow !== 0) begin
      errors++;
      $display("FAIL reset: count=%0d go=%b data=%0d busy=%b done=%b result=%0d flags=%b%b%b%b, want all 0",
               count, go_out, data_out, busy, done, result, rx_error, timeout, mismatch, overflow);
    end
  endtask

  task automatic test_basic;
    do_clear();
    push(5); push(20); push(3); push(17);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (go_out !== 0 || busy !== 1) begin
      errors++;
      $display("FAIL basic_latency: go=%b busy=%b, want go=0 busy=1", go_out, busy);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (go_out !== 1 || data_out !== mq[i]) begin
        errors++;
        $display("FAIL basic_stream[%0d]: go=%b data=%0d, want go=1 data=%0d", i, go_out, data_out, mq[i]);
      end
    end
    tick();
    checks++;
    if (go_out !== 0 || data_out !== 0 || busy !== 1) begin
      errors++;
      $display("FAIL basic_frame_end: go=%b data=%0d busy=%b, want 0 0 1", go_out, data_out, busy);
    end
    finish_in = 1'b1; range_in = 8'd17; error_in = 1'b0;
    tick();
    finish_in = 1'b0;
    checks++;
    if (done !== 1 || busy !== 0 || result !== 17 || mismatch !== (CHK && model_range() != 17) ||
        rx_error !== 0 || timeout !== 0) begin
      errors++;
      $display("FAIL basic_result: done=%b result=%0d mismatch=%b rx_error=%b timeout=%b, want 1 17 0 0 0",
               done, result, mismatch, rx_error, timeout);
    end
  endtask

  task automatic test_mismatch;
    int gos;
    do_clear();
    push(5); push(20); push(3); push(17);
    for (int pass = 0; pass < 2; pass++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      gos = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (go_out === 1) gos++;
      end
      checks++;
      if (gos != 4) begin
        errors++;
        $display("FAIL mismatch_go_cycles[%0d]: got %0d, want 4", pass, gos);
      end
      finish_in = 1'b1; range_in = 8'd16; error_in = (pass == 1);
      tick();
      finish_in = 1'b0; error_in = 1'b0;
      checks++;
      if (done !== 1 || result !== 16 || rx_error !== (pass == 1) ||
          mismatch !== (CHK && pass == 0 && model_range() != 16)) begin
        errors++;
        $display("FAIL mismatch_flag[%0d]: done=%b result=%0d rx_error=%b mismatch=%b, want 1 16 %b %b", pass,
                 done, result, rx_error, mismatch, pass == 1, CHK && pass == 0);
      end
    end
  endtask

  task automatic test_overflow;
    do_clear();
    for (int i = 0; i <= DEPTH; i++) push(WIDTH'($urandom));
    checks++;
    if (count !== CW'(DEPTH) || overflow !== 1) begin
      errors++;
      $display("FAIL overflow_load: count=%0d overflow=%b, want %0d 1", count, overflow, DEPTH);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      checks++;
      if (go_out !== 1 || data_out !== mq[i]) begin
        errors++;
        $display("FAIL overflow_stream[%0d]: go=%b data=%0d, want go=1 data=%0d", i, go_out, data_out, mq[i]);
      end
    end
    tick();
    checks++;
    if (go_out !== 0 || busy !== 1) begin
      errors++;
      $display("FAIL overflow_frame_end: go=%b busy=%b, want 0 1", go_out, busy);
    end
    finish_in = 1'b1; range_in = model_range(); error_in = 1'b0;
    tick();
    finish_in = 1'b0;
    checks++;
    if (done !== 1 || mismatch !== 0 || overflow !== 1 || result !== model_range()) begin
      errors++;
      $display("FAIL overflow_result: done=%b mismatch=%b overflow=%b result=%0d, want 1 0 1 %0d",
               done, mismatch, overflow, result, model_range());
    end
  endtask

  task automatic test_empty;
    do_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1 || go_out !== 0 || busy !== 0 || result !== 0 || mismatch !== 0 || timeout !== 0) begin
      errors++;
      $display("FAIL empty_start: done=%b go=%b busy=%b result=%0d, want 1 0 0 0", done, go_out, busy, result);
    end
    tick();
    checks++;
    if (go_out !== 0 || done !== 1) begin
      errors++;
      $display("FAIL empty_hold: go=%b done=%b, want 0 1", go_out, done);
    end
  endtask

  task automatic test_timeout;
    int k;
    do_clear();
    for (int i = 0; i < 3; i++) push(WIDTH'($urandom_range(1, 255)));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (go_out !== 0 || busy !== 1 || done !== 0) begin
      errors++;
      $display("FAIL timeout_wait_entry: go=%b busy=%b done=%b, want 0 1 0", go_out, busy, done);
    end
    k = 0;
    while (done !== 1 && k < TIMEOUT + 10) begin
      tick();
      k++;
    end
    checks++;
    if (k != TIMEOUT || timeout !== 1 || result !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL timeout: waited=%0d timeout=%b result=%0d busy=%b, want %0d 1 0 0",
               k, timeout, result, busy, TIMEOUT);
    end
  endtask

  task automatic test_reset_mid_send;
    do_clear();
    for (int i = 0; i < 4; i++) push(WIDTH'($urandom));
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (go_out !== 1 || data_out !== mq[1]) begin
      errors++;
      $display("FAIL midreset_sample2: go=%b data=%0d, want 1 %0d", go_out, data_out, mq[1]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mq.delete();
    checks++;
    if (go_out !== 0 || count !== 0 || busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL midreset: go=%b count=%0d busy=%b done=%b, want 0 0 0 0", go_out, count, busy, done);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1 || go_out !== 0 || result !== 0) begin
      errors++;
      $display("FAIL midreset_empty_start: done=%b go=%b result=%0d, want 1 0 0", done, go_out, result);
    end
  endtask

  task automatic test_random;
    int n;
    logic [WIDTH-1:0] rng;
    bit err, exp_mm;
    for (int it = 0; it < 6; it++) begin
      do_clear();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        if (i == n - 1 && it % 2 == 1) start = 1'b1;
        push(WIDTH'($urandom));
      end
      if (it % 2 == 0) begin
        start = 1'b1;
        tick();
      end
      start = 1'b0;
      load_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
        load_data = WIDTH'($urandom);
        tick();
        checks++;
        if (go_out !== 1 || data_out !== mq[i]) begin
          errors++;
          $display("FAIL random%0d_stream[%0d]: go=%b data=%0d, want go=1 data=%0d",
                   it, i, go_out, data_out, mq[i]);
        end
      end
      tick();
      load_valid = 1'b0;
      checks++;
      if (go_out !== 0 || busy !== 1 || count !== CW'(n)) begin
        errors++;
        $display("FAIL random%0d_frame_end: go=%b busy=%b count=%0d, want 0 1 %0d", it, go_out, busy, count, n);
      end
      rng = ($urandom_range(0, 1) == 1) ? model_range() : WIDTH'($urandom);
      err = $urandom_range(0, 3) == 0;
      exp_mm = CHK && rng != model_range() && !err;
      finish_in = 1'b1; range_in = rng; error_in = err;
      tick();
      finish_in = 1'b0; error_in = 1'b0;
      checks++;
      if (done !== 1 || result !== rng || rx_error !== err || mismatch !== exp_mm) begin
        errors++;
        $display("FAIL random%0d_result: done=%b result=%0d rx_error=%b mismatch=%b, want 1 %0d %b %b",
                 it, done, result, rx_error, mismatch, rng, err, exp_mm);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checks++;
      if (go_out !== 1 || data_out !== mq[0] || result !== 0 || done !== 0) begin
        errors++;
        $display("FAIL random%0d_replay: go=%b data=%0d result=%0d done=%b, want 1 %0d 0 0",
                 it, go_out, data_out, result, done, mq[0]);
      end
      for (int i = 0; i < n; i++) tick();
      finish_in = 1'b1; range_in = model_range(); error_in = 1'b1;
      tick();
      finish_in = 1'b0; error_in = 1'b0;
      checks++;
      if (done !== 1 || rx_error !== 1 || mismatch !== 0 || result !== model_range()) begin
        errors++;
        $display("FAIL random%0d_replay_result: done=%b rx_error=%b mismatch=%b result=%0d, want 1 1 0 %0d",
                 it, done, rx_error, mismatch, result, model_range());
      end
    end
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; load_valid = 1'b0; load_data = '0; start = 1'b0;
    finish_in = 1'b0; range_in = '0; error_in = 1'b0;
    test_reset();
    test_basic();
    test_mismatch();
    test_overflow();
    test_empty();
    test_timeout();
    test_reset_mid_send();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
